ecc_enc_stream: RTL

- Streaming extended-Hamming (SECDED) encoder. It is the write-side counterpart of the team's SECDED decoder.
- Accepts K-bit information words on a valid/ready input and emits (n+1)-bit codewords on a valid/ready output, through a parameterizable register pipeline.
- Sits in the DDR3 controller write datapath ahead of the PHY.
- Includes a per-word error-injection mask for exercising the decoder, plus a transfer counter.

---
 rtl/ecc_enc_stream.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ecc_enc_stream.sv
// Streaming extended-Hamming (SECDED) encoder with per-word error injection,
// an elastic register pipeline of 0..2 stages and an output transfer counter.
module ecc_enc_stream #(
  parameter int K       = 8,
  parameter int LATENCY = 1,
  parameter int P0_LSB  = 1,
  localparam int M0     = $clog2(K + 1),
  localparam int M1     = $clog2(K + 1 + M0),
  localparam int M      = $clog2(K + 1 + M1),
  localparam int N      = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [K-1:0] s_data_i,
  input  logic [N:0]   s_inj_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [N:0]   m_data_o,
  output logic         m_inj_o,
  output logic [15:0]  tx_cnt_o
);

  logic [K-1:0]        w_enc_in;
  logic [N:0]          w_info;
  logic [M-1:0][N:0]   w_cov;
  logic [M-1:0]        w_par;
  logic                w_p0;
  logic [N:0]          w_cw;
  logic [N:0]          w_ord;
  logic [15:0]         r_tx_cnt;

  // Data bit j lands on the j-th non-power-of-2 position, i.e. p - floor(log2 p) - 2.
  for (genvar p = 0; p <= N; p++) begin : g_pos
    if (p != 0 && (p & (p - 1)) != 0) begin : g_data
      assign w_info[p] = w_enc_in[p - $clog2(p + 1) - 1];
      assign w_cw[p]   = w_info[p];
    end else if (p == 0) begin : g_p0
      assign w_info[p] = 1'b0;
      assign w_cw[p]   = w_p0;
    end else begin : g_parity
      assign w_info[p] = 1'b0;
      assign w_cw[p]   = w_par[$clog2(p)];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_par
    for (genvar p = 0; p <= N; p++) begin : g_cov
      if (((p >> i) & 1) == 1) begin : g_in
        assign w_cov[i][p] = w_info[p];
      end else begin : g_out
        assign w_cov[i][p] = 1'b0;
      end
    end
    assign w_par[i] = ^w_cov[i];
  end

  assign w_p0 = (^w_info) ^ (^w_par);

  if (P0_LSB != 0) begin : g_ord_lsb
    assign w_ord = w_cw;
  end else begin : g_ord_msb
    assign w_ord = {w_cw[0], w_cw[N:1]};
  end

  if (LATENCY == 0) begin : g_lat0
    assign w_enc_in  = s_data_i;
    assign s_ready_o = m_ready_i;
    assign m_valid_o = s_valid_i;
    assign m_data_o  = w_ord ^ s_inj_i;
    assign m_inj_o   = |s_inj_i;
  end else if (LATENCY == 1) begin : g_lat1
    logic       r_valid;
    logic [N:0] r_data;
    logic       r_inj;
    logic       w_adv;

    assign w_enc_in  = s_data_i;
    assign w_adv     = ~r_valid | m_ready_i;
    assign s_ready_o = w_adv;
    assign m_valid_o = r_valid;
    assign m_data_o  = r_data;
    assign m_inj_o   = r_inj;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_inj   <= 1'b0;
      end else if (w_adv) begin
        r_valid <= s_valid_i;
        if (s_valid_i) begin
          r_data <= w_ord ^ s_inj_i;
          r_inj  <= |s_inj_i;
        end
      end
    end
  end else begin : g_lat2
    // Stage 1 holds the raw word so the encoder tree sits between the two stages.
    logic         r_v1;
    logic [K-1:0] r_d1;
    logic [N:0]   r_m1;
    logic         r_v2;
    logic [N:0]   r_data;
    logic         r_inj;
    logic         w_adv1;
    logic         w_adv2;

    assign w_enc_in  = r_d1;
    assign w_adv2    = ~r_v2 | m_ready_i;
    assign w_adv1    = ~r_v1 | w_adv2;
    assign s_ready_o = w_adv1;
    assign m_valid_o = r_v2;
    assign m_data_o  = r_data;
    assign m_inj_o   = r_inj;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_v1   <= 1'b0;
        r_d1   <= '0;
        r_m1   <= '0;
        r_v2   <= 1'b0;
        r_data <= '0;
        r_inj  <= 1'b0;
      end else begin
        if (w_adv1) begin
          r_v1 <= s_valid_i;
          if (s_valid_i) begin
            r_d1 <= s_data_i;
            r_m1 <= s_inj_i;
          end
        end
        if (w_adv2) begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_data <= w_ord ^ r_m1;
            r_inj  <= |r_m1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_cnt <= '0;
    end else if (m_valid_o && m_ready_i) begin
      r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

  assign tx_cnt_o = r_tx_cnt;

endmodule
